// File: rtl/lsu_dm_master_if.sv
// rtl/lsu_dm_master_if.sv - request/response and data-memory signal bundle of the load/store unit
interface lsu_dm_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_DMWr;
  logic [3:0]  dm_LOADSel;
  logic [1:0]  dm_byte;
  logic [6:0]  dm_addr;
  logic [31:0] dm_din;
  logic [31:0] dm_dout;

  modport master (
    input  req_valid, req_we, req_op, req_addr, req_wdata, dm_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           dm_DMWr, dm_LOADSel, dm_byte, dm_addr, dm_din
  );

  modport slave (
    output req_valid, req_we, req_op, req_addr, req_wdata, dm_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           dm_DMWr, dm_LOADSel, dm_byte, dm_addr, dm_din
  );
endinterface

// File: rtl/lsu_dm_master.sv
// rtl/lsu_dm_master.sv - load/store unit driving the data-memory port
// One request at a time; misaligned loads use two word reads, misaligned stores become byte writes.
module lsu_dm_master #(
  parameter int DM_AW = 9
) (
  input logic             clk,
  input logic             rst,
  lsu_dm_master_if.master bus
);
  localparam logic [3:0] SEL_LW  = 4'b0000;
  localparam logic [3:0] SEL_LB  = 4'b0001;
  localparam logic [3:0] SEL_LBU = 4'b0010;
  localparam logic [3:0] SEL_LH  = 4'b0011;
  localparam logic [3:0] SEL_LHU = 4'b0100;
  localparam logic [3:0] SEL_SB  = 4'b0101;
  localparam logic [3:0] SEL_SH  = 4'b0110;
  localparam logic [3:0] SEL_SW  = 4'b0111;

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_ACC2, S_ACC3, S_RESP} state_t;

  typedef struct packed {
    logic        wr;
    logic [3:0]  sel;
    logic [1:0]  lane;
    logic [6:0]  waddr;
    logic [31:0] din;
  } dm_cmd_t;

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    case (k)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] v);
    case (op[1:0])
      2'b00:   return op[2] ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
      2'b01:   return op[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Low word of {b, a} >> 8*o, i.e. the bytes starting at offset o of word a.
  function automatic logic [31:0] merge(input logic [31:0] a, input logic [31:0] b,
                                        input logic [1:0] o);
    case (o)
      2'd1:    return {b[7:0],  a[31:8]};
      2'd2:    return {b[15:0], a[31:16]};
      2'd3:    return {b[23:0], a[31:24]};
      default: return a;
    endcase
  endfunction

  function automatic dm_cmd_t dm_cmd(input logic we, input logic [2:0] op, input logic [8:0] addr,
                                     input logic [31:0] wdata, input logic mis, input logic [1:0] k);
    dm_cmd_t    c;
    logic [8:0] ba;
    c  = '0;
    ba = addr + {7'd0, k};
    if (mis && we) begin
      c.wr    = 1'b1;
      c.sel   = SEL_SB;
      c.lane  = ba[1:0];
      c.waddr = ba[8:2];
      c.din   = {24'd0, byte_of(wdata, k)};
    end else if (mis) begin
      c.sel   = SEL_LW;
      c.waddr = addr[8:2] + {5'd0, k};
    end else begin
      c.wr    = we;
      c.lane  = addr[1:0];
      c.waddr = addr[8:2];
      case (op[1:0])
        2'b00: begin
          c.sel = we ? SEL_SB : (op[2] ? SEL_LBU : SEL_LB);
          c.din = {24'd0, wdata[7:0]};
        end
        2'b01: begin
          c.sel = we ? SEL_SH : (op[2] ? SEL_LHU : SEL_LH);
          c.din = addr[1] ? {wdata[15:0], 16'd0} : {16'd0, wdata[15:0]};
        end
        default: begin
          c.sel = we ? SEL_SW : SEL_LW;
          c.din = wdata;
        end
      endcase
      if (!we) c.din = '0;
    end
    return c;
  endfunction

  state_t      state_q, state_d, acc_next;
  logic        we_q, we_d, mis_q, mis_d;
  logic [2:0]  op_q, op_d;
  logic [8:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, word_a_q, word_a_d;
  logic [1:0]  last_q, last_d, acc_k;
  logic        ready_q, ready_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  dm_cmd_t     dm_q, dm_d;

  logic [2:0]  req_size;
  logic [31:0] req_end;
  logic        req_mis, req_err;

  always_comb begin
    case (bus.req_op[1:0])
      2'b00:   req_size = 3'd1;
      2'b01:   req_size = 3'd2;
      default: req_size = 3'd4;
    endcase
    req_end = bus.req_addr + {29'd0, req_size} - 32'd1;
    req_err = ((bus.req_addr >> DM_AW) != 32'd0) || ((req_end >> DM_AW) != 32'd0);
    req_mis = (req_size == 3'd2 && bus.req_addr[0]) ||
              (req_size == 3'd4 && bus.req_addr[1:0] != 2'd0);
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mis_d        = mis_q;
    last_d       = last_q;
    word_a_d     = word_a_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    dm_d         = '0;
    acc_k        = 2'd0;
    acc_next     = S_RESP;
    case (state_q)
      S_ACC0:  begin acc_k = 2'd0; acc_next = S_ACC1; end
      S_ACC1:  begin acc_k = 2'd1; acc_next = S_ACC2; end
      S_ACC2:  begin acc_k = 2'd2; acc_next = S_ACC3; end
      S_ACC3:  begin acc_k = 2'd3; acc_next = S_RESP; end
      default: ;
    endcase

    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          op_d    = bus.req_op;
          addr_d  = bus.req_addr[8:0];
          wdata_d = bus.req_wdata;
          mis_d   = req_mis;
          // Index of the final access cycle: stores split into one byte per cycle.
          if (!req_mis)                    last_d = 2'd0;
          else if (!bus.req_we)            last_d = 2'd1;
          else if (req_size == 3'd2)       last_d = 2'd1;
          else                             last_d = 2'd3;
          if (req_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            state_d = S_ACC0;
            dm_d    = dm_cmd(bus.req_we, bus.req_op, bus.req_addr[8:0], bus.req_wdata,
                             req_mis, 2'd0);
          end
        end
      end
      S_ACC0, S_ACC1, S_ACC2, S_ACC3: begin
        if (acc_k == 2'd0) word_a_d = bus.dm_dout;
        if (acc_k == last_q) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          if (!we_q)
            resp_rdata_d = mis_q ? extend(op_q, merge(word_a_q, bus.dm_dout, addr_q[1:0]))
                                 : bus.dm_dout;
        end else begin
          state_d = acc_next;
          dm_d    = dm_cmd(we_q, op_q, addr_q, wdata_q, mis_q, acc_k + 2'd1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mis_q        <= 1'b0;
      last_q       <= '0;
      word_a_q     <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      dm_q         <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mis_q        <= mis_d;
      last_q       <= last_d;
      word_a_q     <= word_a_d;
      ready_q      <= ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      dm_q         <= dm_d;
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.dm_DMWr    = dm_q.wr;
  assign bus.dm_LOADSel = dm_q.sel;
  assign bus.dm_byte    = dm_q.lane;
  assign bus.dm_addr    = dm_q.waddr;
  assign bus.dm_din     = dm_q.din;
endmodule

// File: tb/tb_lsu_dm_master.sv
// tb/tb_lsu_dm_master.sv - directed and random checks of lsu_dm_master against a byte-array model
module tb_lsu_dm_master;
  logic clk, rst, tb_init;
  lsu_dm_master_if bus();

  lsu_dm_master dut (.clk(clk), .rst(rst), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory seen by the DUT: byte array, combinational read, write on rising edge.
  logic [7:0]  mem [0:511];
  logic [31:0] mem_w, mem_sh;
  always_comb begin
    mem_w  = {mem[{bus.dm_addr, 2'd3}], mem[{bus.dm_addr, 2'd2}],
              mem[{bus.dm_addr, 2'd1}], mem[{bus.dm_addr, 2'd0}]};
    mem_sh = mem_w >> {bus.dm_byte, 3'b000};
    case (bus.dm_LOADSel)
      4'b0001: bus.dm_dout = {{24{mem_sh[7]}}, mem_sh[7:0]};
      4'b0010: bus.dm_dout = {24'd0, mem_sh[7:0]};
      4'b0011: bus.dm_dout = {{16{mem_sh[15]}}, mem_sh[15:0]};
      4'b0100: bus.dm_dout = {16'd0, mem_sh[15:0]};
      default: bus.dm_dout = mem_w;
    endcase
  end

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    end else if (bus.dm_DMWr) begin
      case (bus.dm_LOADSel)
        4'b0101: mem[{bus.dm_addr, bus.dm_byte}] <= bus.dm_din[7:0];
        4'b0110: begin
          if (bus.dm_byte[1]) begin
            mem[{bus.dm_addr, 2'd2}] <= bus.dm_din[23:16];
            mem[{bus.dm_addr, 2'd3}] <= bus.dm_din[31:24];
          end else begin
            mem[{bus.dm_addr, 2'd0}] <= bus.dm_din[7:0];
            mem[{bus.dm_addr, 2'd1}] <= bus.dm_din[15:8];
          end
        end
        4'b0111: begin
          mem[{bus.dm_addr, 2'd0}] <= bus.dm_din[7:0];
          mem[{bus.dm_addr, 2'd1}] <= bus.dm_din[15:8];
          mem[{bus.dm_addr, 2'd2}] <= bus.dm_din[23:16];
          mem[{bus.dm_addr, 2'd3}] <= bus.dm_din[31:24];
        end
        default: ;
      endcase
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] ref_mem [0:511];

  int          obs_lat, obs_wr;
  logic        obs_err, obs_resp_ready, obs_resp_dmwr;
  logic [31:0] obs_rdata;
  int          obs_addr[$];
  logic [31:0] obs_din[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] op);
    return (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
    int n = size_of(op);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(addr + i) & 511]) << (8 * i));
    if (!op[2] && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic int q_addr(input int i);
    return (i < obs_addr.size()) ? obs_addr[i] : -1;
  endfunction

  task automatic do_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_op = op;
    bus.req_addr = addr; bus.req_wdata = wdata;
    chk("ready_before_accept", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    obs_addr.delete(); obs_din.delete(); obs_wr = 0; n = 1;
    while (bus.resp_valid !== 1'b1 && n < 12) begin
      obs_addr.push_back(int'(bus.dm_addr));
      obs_din.push_back(bus.dm_din);
      if (bus.dm_DMWr) obs_wr++;
      @(negedge clk);
      n++;
    end
    obs_lat = n; obs_err = bus.resp_err; obs_rdata = bus.resp_rdata;
    obs_resp_ready = bus.req_ready; obs_resp_dmwr = bus.dm_DMWr;
  endtask

  task automatic run_txn(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata);
    int n = size_of(op);
    logic err = (64'(addr) + 64'(n) - 64'd1) > 64'd511;
    logic mis = (addr % n) != 0;
    int exp_lat = err ? 1 : (!mis ? 2 : (we ? n + 1 : 3));
    int exp_wr = (err || !we) ? 0 : (mis ? n : 1);
    logic [31:0] exp_rd = (err || we) ? 32'd0 : ref_load(op, addr);
    do_req(we, op, addr, wdata);
    chk("latency", 32'(obs_lat), 32'(exp_lat));
    chk("resp_err", 32'(obs_err), 32'(err));
    chk("resp_rdata", obs_rdata, exp_rd);
    chk("dmwr_pulses", 32'(obs_wr), 32'(exp_wr));
    chk("resp_ready_low", 32'(obs_resp_ready), 32'd0);
    chk("resp_dmwr_low", 32'(obs_resp_dmwr), 32'd0);
    if (!err) chk("first_dm_addr", 32'(q_addr(0)), (addr >> 2) & 32'h7F);
    if (!err && we)
      for (int i = 0; i < n; i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
  endtask

  task automatic mem_check(input string tag);
    int bad = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk(tag, 32'(bad), 32'd0);
  endtask

  int ops[5] = '{0, 1, 2, 4, 5};
  logic rv[1:6];
  logic rr[1:6];
  logic [31:0] rd[1:6];
  logic [31:0] exp_a, exp_b;
  logic drop;

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_op = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0;
    rst = 1'b1; tb_init = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp", {bus.resp_valid, bus.resp_err, 30'd0}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_dm_ctrl", {17'd0, bus.dm_DMWr, bus.dm_LOADSel, bus.dm_byte, bus.dm_addr}, 32'd0);
    chk("rst_dm_din", bus.dm_din, 32'd0);
    rst = 1'b0; tb_init = 1'b0;

    run_txn(1'b1, 3'b010, 32'h10, 32'h1234_5678);
    chk("sw_dm_addr", 32'(q_addr(0)), 32'd4);
    run_txn(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_aligned", obs_rdata, 32'h1234_5678);

    run_txn(1'b1, 3'b000, 32'h21, 32'h0000_0080);
    run_txn(1'b0, 3'b000, 32'h21, 32'h0);
    chk("lb_sext", obs_rdata, 32'hFFFF_FF80);
    run_txn(1'b0, 3'b100, 32'h21, 32'h0);
    chk("lbu_zext", obs_rdata, 32'h0000_0080);
    run_txn(1'b1, 3'b001, 32'h22, 32'h0000_BEEF);
    chk("sh_din_hi", (obs_din.size() > 0) ? (obs_din[0] >> 16) : 32'hDEAD, 32'h0000_BEEF);
    run_txn(1'b0, 3'b001, 32'h22, 32'h0);
    chk("lh_sext", obs_rdata, 32'hFFFF_BEEF);
    run_txn(1'b0, 3'b101, 32'h22, 32'h0);
    chk("lhu_zext", obs_rdata, 32'h0000_BEEF);

    run_txn(1'b1, 3'b010, 32'h30, 32'h4433_2211);
    run_txn(1'b1, 3'b010, 32'h34, 32'h8877_6655);
    run_txn(1'b0, 3'b010, 32'h31, 32'h0);
    chk("lw_mis_data", obs_rdata, 32'h5544_3322);
    chk("lw_mis_addr_a", 32'(q_addr(0)), 32'd12);
    chk("lw_mis_addr_b", 32'(q_addr(1)), 32'd13);
    run_txn(1'b0, 3'b001, 32'h33, 32'h0);

    run_txn(1'b1, 3'b010, 32'h43, 32'hAABB_CCDD);
    chk("sw_mis_addr_last", 32'(q_addr(3)), 32'h11);
    run_txn(1'b0, 3'b010, 32'h40, 32'h0);
    chk("sw_mis_word0", obs_rdata, 32'hDD00_0000);
    run_txn(1'b0, 3'b010, 32'h44, 32'h0);
    chk("sw_mis_word1", obs_rdata, 32'h00AA_BBCC);

    run_txn(1'b0, 3'b010, 32'h1FE, 32'h0);
    chk("range_lw_1fe", {obs_err, 31'd0} | 32'(obs_addr.size()), 32'h8000_0000);
    run_txn(1'b0, 3'b000, 32'h200, 32'h0);
    run_txn(1'b1, 3'b010, 32'h1FD, 32'hFFFF_FFFF);
    run_txn(1'b0, 3'b000, 32'h1FF, 32'h0);
    chk("range_lb_1ff_ok", 32'(obs_err), 32'd0);
    mem_check("mem_after_directed");

    // Reset while the second byte of a split store is being written.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_op = 3'b010;
    bus.req_addr = 32'h51; bus.req_wdata = 32'hAABB_CCDD;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_dmwr", 32'(bus.dm_DMWr), 32'd0);
    chk("rst_mid_resp", 32'(bus.resp_valid), 32'd0);
    ref_mem[32'h51] = 8'hDD;
    ref_mem[32'h52] = 8'hCC;
    mem_check("mem_after_reset_mid_store");

    // A second request held valid while the first is in flight.
    exp_a = ref_load(3'b010, 32'h10);
    exp_b = ref_load(3'b100, 32'h21);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_op = 3'b010; bus.req_addr = 32'h10;
    @(negedge clk);
    bus.req_op = 3'b100; bus.req_addr = 32'h21;
    drop = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (drop) bus.req_valid = 1'b0;
      rv[c] = bus.resp_valid; rr[c] = bus.req_ready; rd[c] = bus.resp_rdata;
      if (bus.req_ready) drop = 1'b1;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    chk("b2b_busy_ready", {30'd0, rr[1], rr[2]}, 32'd0);
    chk("b2b_first_resp", {31'd0, rv[2]}, 32'd1);
    chk("b2b_first_data", rd[2], exp_a);
    chk("b2b_accept_after_resp", {31'd0, rr[3]}, 32'd1);
    chk("b2b_second_resp", {28'd0, rv[3], rv[4], rv[5], rv[6]}, 32'b0010);
    chk("b2b_second_data", rd[5], exp_b);

    for (int t = 0; t < 150; t++) begin
      logic [2:0]  op;
      logic        we;
      logic [31:0] addr;
      op   = 3'(ops[$urandom_range(0, 4)]);
      we   = op[2] ? 1'b0 : 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 32'h203));
      run_txn(we, op, addr, $urandom);
    end
    mem_check("mem_after_random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
